// File: rtl/op_imm_encoder.sv
// OP-IMM re-encoder: turns a decoded OP-IMM instruction back into an RV32I word,
// tags it with an instruction-memory byte address and queues it in a 2-entry buffer.
package op_imm_pkg;
  typedef logic [31:0] t_word;

  typedef enum logic [2:0] {
    OK_OP_IMM = 3'd0,
    OK_OP     = 3'd1,
    OK_LOAD   = 3'd2,
    OK_STORE  = 3'd3,
    OK_BRANCH = 3'd4,
    OK_OTHER  = 3'd5
  } t_instr_kind;

  typedef enum logic [3:0] {
    FK_ADD  = 4'd0,
    FK_SUB  = 4'd1,
    FK_SLT  = 4'd2,
    FK_SLTU = 4'd3,
    FK_AND  = 4'd4,
    FK_OR   = 4'd5,
    FK_XOR  = 4'd6,
    FK_SLL  = 4'd7,
    FK_SRL  = 4'd8,
    FK_SRA  = 4'd9
  } t_func_kind;

  typedef struct packed {
    t_func_kind  func;
    logic [4:0]  dest_register;
    logic [4:0]  src_register;
    logic [31:0] immediate_value;
  } t_op_imm_instr;

  typedef struct packed {
    t_instr_kind   kind;
    t_op_imm_instr payload;
  } t_decoded_instr;
endpackage

module op_imm_encoder
  import op_imm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  t_decoded_instr       in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output t_word                out_word,
  output logic [31:0]          out_addr,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [1:0]           count_q, count_d;
  t_word                head_word_q, head_word_d;
  logic [31:0]          head_addr_q, head_addr_d;
  t_word                tail_word_q, tail_word_d;
  logic [31:0]          tail_addr_q, tail_addr_d;
  logic [31:0]          next_addr_q, next_addr_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic        func_known;
  logic        is_shift;
  logic        is_sra;
  logic [2:0]  funct3;
  logic        arith_imm_ok;
  logic        shamt_ok;
  logic        enc_legal;
  t_word       enc_word;
  logic [31:0] imm;

  logic accept;
  logic push;
  logic pop;
  logic drop;

  assign imm = in_instr.payload.immediate_value;

  always_comb begin
    func_known = 1'b1;
    is_shift   = 1'b0;
    is_sra     = 1'b0;
    funct3     = 3'b000;
    case (in_instr.payload.func)
      FK_ADD:  funct3 = 3'b000;
      FK_SLT:  funct3 = 3'b010;
      FK_SLTU: funct3 = 3'b011;
      FK_XOR:  funct3 = 3'b100;
      FK_OR:   funct3 = 3'b110;
      FK_AND:  funct3 = 3'b111;
      FK_SLL: begin
        funct3   = 3'b001;
        is_shift = 1'b1;
      end
      FK_SRL: begin
        funct3   = 3'b101;
        is_shift = 1'b1;
      end
      FK_SRA: begin
        funct3   = 3'b101;
        is_shift = 1'b1;
        is_sra   = 1'b1;
      end
      default: func_known = 1'b0;
    endcase

    // A 12-bit immediate survives sign extension only if bits 31..11 all match.
    arith_imm_ok = (&imm[31:11]) | ~(|imm[31:11]);
    shamt_ok     = ~(|imm[31:5]);
    enc_legal    = (in_instr.kind == OK_OP_IMM) && func_known &&
                   (is_shift ? shamt_ok : arith_imm_ok);

    enc_word = {(is_shift ? {(is_sra ? 7'b0100000 : 7'b0000000), imm[4:0]} : imm[11:0]),
                in_instr.payload.src_register,
                funct3,
                in_instr.payload.dest_register,
                7'b0010011};
  end

  assign in_ready   = (count_q != 2'd2);
  assign out_valid  = (count_q != 2'd0);
  assign out_word   = head_word_q;
  assign out_addr   = head_addr_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && enc_legal;
  assign drop   = accept && !enc_legal;
  assign pop    = out_valid && out_ready;

  always_comb begin
    count_d      = count_q;
    head_word_d  = head_word_q;
    head_addr_d  = head_addr_q;
    tail_word_d  = tail_word_q;
    tail_addr_d  = tail_addr_q;
    next_addr_d  = next_addr_q;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;

    if (push) begin
      next_addr_d = next_addr_q + 32'd4;
    end

    if (drop) begin
      err_sticky_d = 1'b1;
      if (err_count_q != {ERR_CNT_W{1'b1}}) begin
        err_count_d = err_count_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
    end

    // Head register keeps the last popped entry while the queue is empty.
    case (count_q)
      2'd0: begin
        if (push) begin
          head_word_d = enc_word;
          head_addr_d = next_addr_q;
          count_d     = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_word_d = enc_word;
          head_addr_d = next_addr_q;
        end else if (push) begin
          tail_word_d = enc_word;
          tail_addr_d = next_addr_q;
          count_d     = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_word_d = tail_word_q;
          head_addr_d = tail_addr_q;
          count_d     = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= 2'd0;
      head_word_q  <= '0;
      head_addr_q  <= '0;
      tail_word_q  <= '0;
      tail_addr_q  <= '0;
      next_addr_q  <= BASE_ADDR;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      count_q      <= count_d;
      head_word_q  <= head_word_d;
      head_addr_q  <= head_addr_d;
      tail_word_q  <= tail_word_d;
      tail_addr_q  <= tail_addr_d;
      next_addr_q  <= next_addr_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

endmodule

// File: tb/tb_op_imm_encoder.sv
// Bench for op_imm_encoder: directed scenarios plus random traffic against a queue model.
// A second instance with BASE_ADDR near the top of the address space exercises wrap.
module tb_op_imm_encoder;
  import op_imm_pkg::*;

  localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFFC;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready, in_ready_w;
  t_decoded_instr in_instr;
  logic           out_valid, out_valid_w;
  logic           out_ready;
  t_word          out_word, out_word_w;
  logic [31:0]    out_addr, out_addr_w;
  logic           err_sticky, err_sticky_w;
  logic [7:0]     err_count, err_count_w;

  always #5 clk = ~clk;

  op_imm_encoder u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .err_sticky(err_sticky),
    .err_count(err_count)
  );

  op_imm_encoder #(.BASE_ADDR(WRAP_BASE)) u_dut_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_instr(in_instr), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_word(out_word_w), .out_addr(out_addr_w), .err_sticky(err_sticky_w),
    .err_count(err_count_w)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_wq[$];
  logic [31:0] m_aq[$];
  logic [31:0] m_next;
  int          m_err;
  bit          m_sticky;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic t_decoded_instr mk(input logic [2:0] kind, input logic [3:0] func,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    t_decoded_instr x;
    x.kind                    = t_instr_kind'(kind);
    x.payload.func            = t_func_kind'(func);
    x.payload.dest_register   = rd;
    x.payload.src_register    = rs1;
    x.payload.immediate_value = imm;
    return x;
  endfunction

  // Reference: instruction fields assembled by weighted sums, legality by signed range.
  function automatic void ref_encode(input t_decoded_instr x, output bit legal,
                                     output logic [31:0] w);
    logic [31:0] f3;
    logic [31:0] f7;
    logic [31:0] imm_field;
    bit          shift;
    int          s_imm;
    legal = 1;
    shift = 0;
    f3    = 0;
    f7    = 0;
    s_imm = x.payload.immediate_value;
    case (x.payload.func)
      FK_ADD:  f3 = 0;
      FK_SLT:  f3 = 2;
      FK_SLTU: f3 = 3;
      FK_XOR:  f3 = 4;
      FK_OR:   f3 = 6;
      FK_AND:  f3 = 7;
      FK_SLL:  begin f3 = 1; shift = 1; end
      FK_SRL:  begin f3 = 5; shift = 1; end
      FK_SRA:  begin f3 = 5; shift = 1; f7 = 32; end
      default: legal = 0;
    endcase
    if (x.kind != OK_OP_IMM) legal = 0;
    if (shift) begin
      if (x.payload.immediate_value > 32'd31) legal = 0;
      imm_field = (x.payload.immediate_value % 32) + f7 * 32;
    end else begin
      if (s_imm < -2048 || s_imm > 2047) legal = 0;
      imm_field = x.payload.immediate_value % 4096;
    end
    w = 32'd19 + 32'(x.payload.dest_register) * 128 + f3 * 4096
        + 32'(x.payload.src_register) * 32768 + imm_field * 1048576;
  endfunction

  task automatic check_all();
    chk("in_ready", in_ready, m_wq.size() < 2);
    chk("out_valid", out_valid, m_wq.size() != 0);
    chk("err_count", err_count, m_err);
    chk("err_sticky", err_sticky, m_sticky);
    chk("w_in_ready", in_ready_w, m_wq.size() < 2);
    chk("w_out_valid", out_valid_w, m_wq.size() != 0);
    chk("w_err_count", err_count_w, m_err);
    if (m_wq.size() != 0) begin
      chk("out_word", out_word, m_wq[0]);
      chk("out_addr", out_addr, m_aq[0]);
      chk("w_out_word", out_word_w, m_wq[0]);
      chk("w_out_addr", out_addr_w, m_aq[0] + WRAP_BASE);
    end
  endtask

  task automatic cycle(input logic v, input t_decoded_instr ins, input logic rdy);
    bit          acc, pop, legal;
    logic [31:0] w;
    in_valid  = v;
    in_instr  = ins;
    out_ready = rdy;
    acc = v && (m_wq.size() < 2);
    pop = rdy && (m_wq.size() != 0);
    @(posedge clk);
    if (reset) begin
      m_wq.delete();
      m_aq.delete();
      m_next   = 0;
      m_err    = 0;
      m_sticky = 0;
    end else begin
      if (pop) begin
        void'(m_wq.pop_front());
        void'(m_aq.pop_front());
      end
      if (acc) begin
        ref_encode(ins, legal, w);
        if (legal) begin
          m_wq.push_back(w);
          m_aq.push_back(m_next);
          m_next = m_next + 4;
        end else begin
          m_sticky = 1;
          if (m_err < 255) m_err++;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, '0, 1'b0);
    reset = 1'b0;
    chk("rst_out_word", out_word, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_in_ready", in_ready, 32'h1);
  endtask

  function automatic t_decoded_instr rand_instr();
    logic [2:0]  kind;
    logic [31:0] imm;
    kind = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 5)) : 3'd0;
    case ($urandom_range(0, 3))
      0:       imm = $urandom_range(0, 31);
      1:       imm = $urandom_range(0, 4095) - 32'd2048;
      2:       imm = $urandom;
      default: imm = $urandom_range(0, 63);
    endcase
    return mk(kind, 4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), imm);
  endfunction

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    m_next    = 0;
    m_err     = 0;
    m_sticky  = 0;
    @(negedge clk);
    do_reset();

    // ADDI x1,x2,-1
    cycle(1'b1, mk(3'd0, FK_ADD, 5'd1, 5'd2, 32'hFFFF_FFFF), 1'b1);
    chk("addi_word", out_word, 32'hFFF1_0093);
    chk("addi_addr", out_addr, 32'h0);
    chk("addi_wrap_addr", out_addr_w, WRAP_BASE);
    cycle(1'b0, '0, 1'b1);

    // SRAI / SRLI x3,x4,5
    do_reset();
    cycle(1'b1, mk(3'd0, FK_SRA, 5'd3, 5'd4, 32'd5), 1'b1);
    chk("srai_word", out_word, 32'h4052_5193);
    chk("srai_addr", out_addr, 32'h0);
    cycle(1'b1, mk(3'd0, FK_SRL, 5'd3, 5'd4, 32'd5), 1'b1);
    chk("srli_word", out_word, 32'h0052_5193);
    chk("srli_addr", out_addr, 32'h4);
    chk("srli_wrap_addr", out_addr_w, 32'h0);
    cycle(1'b0, '0, 1'b1);

    // Illegal encodings are dropped and counted
    do_reset();
    cycle(1'b1, mk(3'd0, FK_ADD, 5'd1, 5'd1, 32'd2048), 1'b1);
    cycle(1'b1, mk(3'd0, FK_SLL, 5'd1, 5'd1, 32'd32), 1'b1);
    cycle(1'b1, mk(3'd0, FK_SUB, 5'd1, 5'd1, 32'd1), 1'b1);
    chk("illegal_cnt", err_count, 32'd3);
    chk("illegal_sticky", err_sticky, 32'd1);
    chk("illegal_no_out", out_valid, 32'd0);
    cycle(1'b1, mk(3'd0, FK_OR, 5'd5, 5'd6, 32'd7), 1'b1);
    chk("after_illegal_addr", out_addr, 32'h0);
    cycle(1'b0, '0, 1'b1);

    // Backpressure: third back-to-back input must stall
    do_reset();
    cycle(1'b1, mk(3'd0, FK_XOR, 5'd7, 5'd8, 32'd100), 1'b0);
    cycle(1'b1, mk(3'd0, FK_AND, 5'd9, 5'd10, 32'hFFFF_F800), 1'b0);
    chk("bp_in_ready", in_ready, 32'd0);
    cycle(1'b1, mk(3'd0, FK_SLT, 5'd11, 5'd12, 32'd1), 1'b0);
    chk("bp_hold_addr", out_addr, 32'h0);
    cycle(1'b1, mk(3'd0, FK_SLT, 5'd11, 5'd12, 32'd1), 1'b1);
    chk("bp_drain_addr", out_addr, 32'h4);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

    // Reset with two entries queued
    cycle(1'b1, mk(3'd0, FK_ADD, 5'd1, 5'd2, 32'd3), 1'b0);
    cycle(1'b1, mk(3'd0, FK_ADD, 5'd1, 5'd2, 32'd4), 1'b0);
    cycle(1'b1, mk(3'd1, FK_ADD, 5'd1, 5'd2, 32'd4), 1'b0);
    do_reset();
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_err", err_count, 32'd0);
    cycle(1'b1, mk(3'd0, FK_SLTU, 5'd2, 5'd3, 32'd9), 1'b1);
    chk("rst_first_addr", out_addr, 32'h0);

    // Saturating error counter
    for (int i = 0; i < 260; i++) cycle(1'b1, mk(3'd2, FK_ADD, 5'd0, 5'd0, 32'd0), 1'b1);
    chk("err_saturate", err_count, 32'd255);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/op_imm_encoder.md
Name: op_imm_encoder

Overview:
- Streaming encoder for decoded OP-IMM instructions. It converts a t_decoded_instr (kind OK_OP_IMM, payload t_op_imm_instr) back into a 32-bit RV32I instruction word.
- Tags each word with an instruction-memory byte address and buffers results in a 2-entry output queue.
- Feeds the instruction-memory loader and the decoder round-trip self-check. Illegal encodings are dropped and counted.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address assigned to the first legal encoded word after reset.
- ERR_CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_instr is valid.
- in_ready  output  1  block accepts in_instr this cycle.
- in_instr  input  $bits(t_decoded_instr)  decoded instruction to encode.
- out_valid  output  1  out_word/out_addr are valid.
- out_ready  input  1  consumer takes the head entry this cycle.
- out_word  output  32  encoded instruction word (t_word).
- out_addr  output  32  byte address of out_word.
- err_sticky  output  1  set on the first dropped instruction; cleared only by reset.
- err_count  output  ERR_CNT_W  number of dropped instructions, saturating.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_word=0, out_addr=0, err_sticky=0, err_count=0, next-address register=BASE_ADDR, queue empty.
- Reset mid-operation discards every queued entry and restarts addressing at BASE_ADDR.
- Accept: an instruction is accepted on a rising edge with in_valid && in_ready.
- in_ready = (queue count < 2). It is derived from registered count only, so a pop in the same cycle does not open a slot.
- Legality, checked on the accepted instruction:
  - kind != OK_OP_IMM -> illegal.
  - func FK_SUB, or any value outside ADD/SLT/SLTU/AND/OR/XOR/SLL/SRL/SRA -> illegal.
  - ADD/SLT/SLTU/AND/OR/XOR: immediate_value[31:11] must be all-equal (12-bit sign-extendable), otherwise illegal.
  - SLL/SRL/SRA: immediate_value[31:5] must be 0, otherwise illegal.
- Encoding (legal case):
  - [6:0]=7'b0010011, [11:7]=dest_register, [19:15]=src_register.
  - [14:12]: ADD 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
  - Arithmetic/logic ops: [31:20]=immediate_value[11:0].
  - Shifts: [24:20]=immediate_value[4:0], [31:25]=7'b0100000 for SRA, 7'b0000000 for SLL/SRL.
- Legal accept:
  - Pushes {word, next_addr}, then next_addr += 4.
  - Address arithmetic is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - Latency 1: the entry is visible on out_* in the cycle after the accepting edge when the queue was empty.
- Illegal accept: nothing is pushed, next_addr is unchanged, err_sticky<=1, err_count increments, saturating at 2^ERR_CNT_W-1. The handshake still completes (in_ready rules are unchanged).
- Output: out_valid = (count != 0). out_word/out_addr show the head entry and stay stable while out_valid && !out_ready. Pop on out_valid && out_ready.
- Simultaneous push and pop with count==1: count stays 1, and the new entry becomes the head on the next cycle.
- FIFO order is strict. out_word/out_addr hold the last popped value while empty; the bench checks them only while out_valid.

Test Plan:
- ADDI x1,x2,-1 (FK_ADD, rd=1, rs1=2, imm=32'hFFFF_FFFF), out_ready=1 -> one cycle later out_valid=1, out_word=32'hFFF1_0093, out_addr=BASE_ADDR.
- SRAI x3,x4,5 then SRLI x3,x4,5 -> words 32'h4052_5193 and 32'h0052_5193 at addresses 0x0 and 0x4; feeding each to Decoder returns the original func/regs/immediate.
- FK_ADD imm=2048, then SLLI shamt=32, then FK_SUB -> no output, err_count=3, err_sticky=1; next legal instruction is tagged addr 0x0.
- out_ready=0 with back-to-back valid inputs -> in_ready drops after 2 accepts; out_word holds the first word; raising out_ready drains both entries in order, and in_ready returns the cycle after count<2.
- BASE_ADDR=32'hFFFF_FFFC with two legal instructions -> out_addr 32'hFFFF_FFFC then 32'h0000_0000.
- Assert reset with 2 entries queued -> next cycle out_valid=0, in_ready=1, err_count=0; the first new word gets addr BASE_ADDR.
